// File: rtl/outport_rr_arbiter_if.sv
// Bundle between the input channels, the round-robin output-port arbiter and the downstream port.
// The slave side is the arbiter; the master side drives channel flits and the downstream ack.
interface outport_rr_arbiter_if #(
    parameter int unsigned DATA_WIDTH      = 70,
    parameter int unsigned NUMBER_CHANNELS = 5
);
    logic [NUMBER_CHANNELS*DATA_WIDTH-1:0] in_data;
    logic [NUMBER_CHANNELS-1:0]            in_val;
    logic [NUMBER_CHANNELS-1:0]            in_ack;
    logic [DATA_WIDTH-1:0]                 out_data;
    logic                                  out_val;
    logic                                  out_ack;
    logic [NUMBER_CHANNELS-1:0]            grant;
    logic                                  timeout_err;

    modport slave (
        input  in_data, in_val, out_ack,
        output in_ack, out_data, out_val, grant, timeout_err
    );

    modport master (
        output in_data, in_val, out_ack,
        input  in_ack, out_data, out_val, grant, timeout_err
    );
endinterface

// File: rtl/outport_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered output port.
// A grant is held until the last flit is accepted or the owner stalls for TIMEOUT cycles.
module outport_rr_arbiter #(
    parameter int unsigned DATA_WIDTH      = 70,
    parameter int unsigned NUMBER_CHANNELS = 5,
    parameter int unsigned TIMEOUT         = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    outport_rr_arbiter_if.slave        bus
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned NC    = NUMBER_CHANNELS;
    localparam int unsigned PTR_W = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NC - 1);
    localparam logic [CW-1:0]    NC_W    = CW'(NC);

    logic [0:0]       state,       state_nxt;
    logic [PTR_W-1:0] rr_ptr,      rr_ptr_nxt;
    logic [PTR_W-1:0] gnt_idx,     gnt_idx_nxt;
    logic [NC-1:0]    grant_q,     grant_nxt;
    logic [CNT_W-1:0] stall_cnt,   stall_nxt;
    logic [DW-1:0]    out_data_q,  out_data_nxt;
    logic             out_val_q,   out_val_nxt;
    logic             to_err_q,    to_err_nxt;

    logic             space;
    logic [NC-1:0]    in_ack_c;
    logic             xfer;
    logic [DW-1:0]    flit;
    logic             last;
    logic [PTR_W-1:0] ptr_inc;
    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    logic [CW-1:0]    cand;

    assign space = !out_val_q || bus.out_ack;
    assign xfer  = |in_ack_c;
    assign last  = flit[DW-1];
    assign ptr_inc = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;

    // Only the locked owner may be acked, and only when the output register can take the flit.
    always_comb begin
        in_ack_c = '0;
        if (state == ST_LOCKED && space) begin
            in_ack_c = grant_q & bus.in_val;
        end
    end

    always_comb begin
        flit = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (grant_q[i]) begin
                flit = bus.in_data[i*DW +: DW];
            end
        end
    end

    // First requester at or above rr_ptr, wrapping past the top channel.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NC; off++) begin
            cand = {1'b0, rr_ptr} + CW'(off);
            if (cand >= NC_W) begin
                cand = cand - NC_W;
            end
            if (!sel_found && bus.in_val[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_idx_nxt  = gnt_idx;
        grant_nxt    = grant_q;
        stall_nxt    = stall_cnt;
        out_data_nxt = out_data_q;
        out_val_nxt  = out_val_q;
        to_err_nxt   = 1'b0;

        if (xfer) begin
            out_data_nxt = flit;
            out_val_nxt  = 1'b1;
        end else if (bus.out_ack) begin
            out_val_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                stall_nxt = '0;
                if (sel_found) begin
                    state_nxt   = ST_LOCKED;
                    gnt_idx_nxt = sel_idx;
                    grant_nxt   = NC'(1) << sel_idx;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    stall_nxt = '0;
                    if (last) begin
                        state_nxt  = ST_IDLE;
                        grant_nxt  = '0;
                        rr_ptr_nxt = ptr_inc;
                    end
                end else begin
                    if (stall_cnt != CNT_MAX) begin
                        stall_nxt = stall_cnt + 1'b1;
                    end
                    // Revoke a stalled owner; the flit already in the output register is kept.
                    if (TO_EN && stall_cnt == TO_LAST) begin
                        state_nxt  = ST_IDLE;
                        grant_nxt  = '0;
                        rr_ptr_nxt = ptr_inc;
                        stall_nxt  = '0;
                        to_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            grant_q    <= '0;
            stall_cnt  <= '0;
            out_data_q <= '0;
            out_val_q  <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            gnt_idx    <= gnt_idx_nxt;
            grant_q    <= grant_nxt;
            stall_cnt  <= stall_nxt;
            out_data_q <= out_data_nxt;
            out_val_q  <= out_val_nxt;
            to_err_q   <= to_err_nxt;
        end
    end

    assign bus.in_ack      = in_ack_c;
    assign bus.out_data    = out_data_q;
    assign bus.out_val     = out_val_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = to_err_q;
endmodule

// File: doc/outport_rr_arbiter.md
OUTPORT_RR_ARBITER -- requirements
Module: outport_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 70, meaning flit width; bit DATA_WIDTH-1 is the end-of-packet (last) flag.
REQ-002 SHALL have parameter NUMBER_CHANNELS, default 5, meaning number of requesting input channels (local = channel 4).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning stall cycles before a locked grant is revoked; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port in_data, input, NUMBER_CHANNELS*DATA_WIDTH, meaning channel i flit at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_val, input, NUMBER_CHANNELS, meaning per-channel flit valid.
REQ-008 SHALL have port in_ack, output, NUMBER_CHANNELS, meaning per-channel flit accepted this cycle.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, meaning registered flit to the output port.
REQ-010 SHALL have port out_val, output, 1, meaning out_data valid.
REQ-011 SHALL have port out_ack, input, 1, meaning downstream accepts out_data this cycle.
REQ-012 SHALL have port grant, output, NUMBER_CHANNELS, meaning one-hot locked owner, all-zero when idle.
REQ-013 SHALL have port timeout_err, output, 1, meaning one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 A transfer SHALL occur on a channel or on the output in any cycle where its val and ack are both 1.
REQ-015 The FSM SHALL have exactly two states: IDLE and LOCKED.
REQ-016 In IDLE with any in_val set, the block SHALL select the first set channel at or above rr_ptr (wrapping NUMBER_CHANNELS-1 to 0), load grant one-hot and enter LOCKED at the next edge.
REQ-017 In IDLE, in_ack SHALL be all-zero; a flit is never accepted in the arbitration cycle.
REQ-018 In LOCKED, in_ack[g] SHALL equal in_val[g] AND space, where g is the granted channel and space = (!out_val OR out_ack); all other in_ack bits SHALL be 0.
REQ-019 On an input transfer, out_data SHALL load the granted flit and out_val SHALL be 1 at the next edge (latency: one cycle input to output).
REQ-020 When out_ack=1 and no input transfer occurs in the same cycle, out_val SHALL clear at the next edge; out_data holds otherwise.
REQ-021 An accepted flit with bit DATA_WIDTH-1 set SHALL return the FSM to IDLE, clear grant and set rr_ptr to g+1 mod NUMBER_CHANNELS.
REQ-022 Back-to-back packets from the same channel SHALL incur exactly one idle arbitration cycle between them.
REQ-023 In LOCKED, a stall counter SHALL increment each cycle without an input transfer and clear on each transfer; it saturates, never wraps.
REQ-024 When TIMEOUT>0 and the stall counter reaches TIMEOUT, the block SHALL go to IDLE, clear grant, advance rr_ptr to g+1 mod NUMBER_CHANNELS and pulse timeout_err for one cycle.
REQ-025 If a last flit transfers in the same cycle the counter would reach TIMEOUT, the normal end-of-packet path SHALL win and timeout_err SHALL stay 0.
REQ-026 Changes to in_val of non-granted channels during LOCKED SHALL have no effect.
REQ-027 The pending output flit SHALL be kept and delivered after a timeout revocation.

Reset
REQ-028 While rst=1: FSM=IDLE, rr_ptr=0, grant=0, in_ack=0, out_val=0, out_data=0, timeout_err=0, stall counter=0.
REQ-029 An assertion of rst mid-packet SHALL discard the held flit and the lock immediately, without waiting for a clock edge.

Verification
REQ-030 Reset, then in_val=5'b00110 with single-flit packets and out_ack=1 -> grant=00010 then 00100, rr_ptr=3 afterwards, out_val high one cycle per flit.
REQ-031 Channel 0 sends a 4-flit packet while channel 3 requests -> channel 3 in_ack stays 0 until channel 0's last flit is accepted; grant switches to 01000 after one idle cycle.
REQ-032 out_ack held 0 for 10 cycles in LOCKED -> at most one flit is accepted, out_data stable, no flit lost or duplicated after out_ack returns to 1.
REQ-033 TIMEOUT=8, granted channel drops in_val mid-packet -> timeout_err pulses at stall count 8, grant=0, next-higher requester granted.
REQ-034 All 5 channels continuously requesting single-flit packets -> grant order 0,1,2,3,4,0 and equal counts over 100 packets.
REQ-035 rst asserted asynchronously while out_val=1 -> out_val, grant and in_ack are 0 before the next clk edge.
